// File: rtl/ccm_ctr_feeder_if.sv
// Bundles the upstream write port, the ccm_ctr core byte port and the status
// outputs of ccm_ctr_feeder.
interface ccm_ctr_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             wr_last;
  logic             wr_full;
  logic [WIDTH-1:0] input_data;
  logic             input_en;
  logic             input_last;
  logic             max_in_en_val;
  logic [15:0]      tx_cnt;
  logic             busy;
  logic             ovf_err;

  modport master (
    output wr_data, wr_en, wr_last, max_in_en_val,
    input  wr_full, input_data, input_en, input_last, tx_cnt, busy, ovf_err
  );

  modport slave (
    input  wr_data, wr_en, wr_last, max_in_en_val,
    output wr_full, input_data, input_en, input_last, tx_cnt, busy, ovf_err
  );
endinterface

// File: rtl/ccm_ctr_feeder.sv
// Staging FIFO plus frame FSM that feeds bytes to the ccm_ctr core, honouring
// core back-pressure and forcing one idle cycle between frames.
module ccm_ctr_feeder #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic             clk,
  input logic             reset,
  ccm_ctr_feeder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] inData_q;
  logic             inEn_q, inLast_q, ovf_q;
  logic [15:0]      txCnt_q, txCnt_d;

  logic             full, empty, doWrite, doPop;
  logic [WIDTH:0]   head;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign doWrite = bus.wr_en && !full && !reset;
  assign head    = mem_q[rdPtr_q];
  assign doPop   = !empty && !bus.max_in_en_val && (state_q == IDLE || state_q == SEND);

  // Each entry carries the last-byte marker in its top bit.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem_q[wrPtr_q] <= {bus.wr_last, bus.wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      inEn_q   <= 1'b0;
      inLast_q <= 1'b0;
      inData_q <= '0;
      txCnt_q  <= '0;
      state_q  <= IDLE;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)   rdPtr_q <= rdPtr_q + 1'b1;
      // A write against a full FIFO is dropped even when a pop frees a slot.
      case ({doWrite, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (bus.wr_en && full) ovf_q <= 1'b1;
      inEn_q   <= doPop;
      inLast_q <= doPop && head[WIDTH];
      if (doPop) inData_q <= head[WIDTH-1:0];
      txCnt_q  <= txCnt_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    txCnt_d = txCnt_q;
    case (state_q)
      IDLE: begin
        if (doPop) begin
          txCnt_d = 16'd1;
          state_d = head[WIDTH] ? GAP : SEND;
        end
      end
      SEND: begin
        if (doPop) begin
          if (txCnt_q != 16'hFFFF) txCnt_d = txCnt_q + 16'd1;
          if (head[WIDTH]) state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.wr_full    = full;
  assign bus.input_data = inData_q;
  assign bus.input_en   = inEn_q;
  assign bus.input_last = inLast_q;
  assign bus.tx_cnt     = txCnt_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.ovf_err    = ovf_q;
endmodule

// File: tb/tb_ccm_ctr_feeder.sv
// Directed bench for ccm_ctr_feeder: written bytes go into a scoreboard queue
// and are popped and compared whenever the core port shows input_en.
module tb_ccm_ctr_feeder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   issued = 0;
  int   base;
  logic prevLastOut = 1'b0;
  logic [8:0] sb [$];

  ccm_ctr_feeder_if #(.WIDTH(8)) bus ();

  ccm_ctr_feeder #(.WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock and score whatever the core port shows after the edge.
  task automatic cycle();
    logic bp;
    logic [8:0] exp;
    bp = bus.max_in_en_val;
    @(posedge clk);
    #1;
    if (bus.input_en === 1'b1) begin
      checkBit("no_issue_after_backpressure", bp, 1'b0);
      checkBit("idle_cycle_between_frames", prevLastOut, 1'b0);
      checkBit("scoreboard_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        checkOutput("out_data", 16'(bus.input_data), 16'(exp[7:0]));
        checkBit("out_last", bus.input_last, exp[8]);
        issued++;
      end
    end else begin
      checkBit("last_without_en", bus.input_last, 1'b0);
    end
    prevLastOut = bus.input_en & bus.input_last;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic last, input logic expectAccept);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.wr_last = last;
    if (expectAccept) sb.push_back({last, d});
    cycle();
    bus.wr_en   = 1'b0;
    bus.wr_last = 1'b0;
  endtask

  task automatic drain(input int budget, input logic toggleBp);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      if (toggleBp) bus.max_in_en_val = ~bus.max_in_en_val;
      cycle();
      n++;
    end
    checkBit("drain_within_budget", sb.size() == 0, 1'b1);
    bus.max_in_en_val = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    reset             = 1'b1;
    bus.wr_en         = 1'b1;
    bus.wr_data       = 8'hAA;
    bus.wr_last       = 1'b1;
    bus.max_in_en_val = 1'b0;
    cycle();
    cycle();
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_last = 1'b0;
    checkBit("rst_input_en", bus.input_en, 1'b0);
    checkBit("rst_input_last", bus.input_last, 1'b0);
    checkOutput("rst_input_data", 16'(bus.input_data), 16'h0);
    checkOutput("rst_tx_cnt", bus.tx_cnt, 16'h0);
    checkBit("rst_busy", bus.busy, 1'b0);
    checkBit("rst_ovf_err", bus.ovf_err, 1'b0);
    checkBit("rst_wr_full", bus.wr_full, 1'b0);
    repeat (3) cycle();

    $display("[TB] five-byte frame");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), i == 5, 1'b1);
      if (i >= 2) checkBit("t1_consecutive_en", bus.input_en, 1'b1);
    end
    cycle();
    checkBit("t1_last_en", bus.input_en, 1'b1);
    checkBit("t1_last_flag", bus.input_last, 1'b1);
    checkOutput("t1_tx_cnt", bus.tx_cnt, 16'd5);
    checkBit("t1_busy_in_gap", bus.busy, 1'b1);
    cycle();
    checkBit("t1_busy_dropped", bus.busy, 1'b0);
    checkBit("t1_en_after", bus.input_en, 1'b0);
    checkOutput("t1_tx_cnt_hold", bus.tx_cnt, 16'd5);

    $display("[TB] fill under back-pressure and overflow");
    base = issued;
    bus.max_in_en_val = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h10 + i), i == 15, 1'b1);
    checkBit("t2_wr_full", bus.wr_full, 1'b1);
    checkBit("t2_no_issue", bus.input_en, 1'b0);
    checkBit("t2_ovf_clear", bus.ovf_err, 1'b0);
    applyStimulus(8'hEE, 1'b0, 1'b0);
    checkBit("t2_ovf_set", bus.ovf_err, 1'b1);
    checkBit("t2_still_full", bus.wr_full, 1'b1);
    bus.max_in_en_val = 1'b0;
    drain(40, 1'b0);
    checkOutput("t2_issued", 16'(issued - base), 16'd16);
    checkOutput("t2_tx_cnt", bus.tx_cnt, 16'd16);
    checkBit("t2_not_full", bus.wr_full, 1'b0);
    checkBit("t2_ovf_sticky", bus.ovf_err, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkBit("t2_ovf_reset", bus.ovf_err, 1'b0);
    checkOutput("t2_tx_cnt_reset", bus.tx_cnt, 16'd0);

    $display("[TB] toggling back-pressure");
    base = issued;
    for (int i = 0; i < 10; i++) begin
      bus.max_in_en_val = ~bus.max_in_en_val;
      applyStimulus(8'(8'h30 + i), i == 9, 1'b1);
    end
    drain(60, 1'b1);
    checkOutput("t3_issued", 16'(issued - base), 16'd10);
    checkOutput("t3_tx_cnt", bus.tx_cnt, 16'd10);
    checkBit("t3_busy", bus.busy, 1'b0);

    $display("[TB] back-to-back frames");
    applyStimulus(8'h41, 1'b0, 1'b1);
    applyStimulus(8'h42, 1'b0, 1'b1);
    applyStimulus(8'h43, 1'b1, 1'b1);
    applyStimulus(8'h50, 1'b1, 1'b1);
    checkBit("t4_first_last", bus.input_last, 1'b1);
    cycle();
    checkBit("t4_gap_bubble", bus.input_en, 1'b0);
    cycle();
    checkBit("t4_second_en", bus.input_en, 1'b1);
    checkBit("t4_second_last", bus.input_last, 1'b1);
    checkOutput("t4_tx_cnt", bus.tx_cnt, 16'd1);
    drain(10, 1'b0);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h60 + i), 1'b0, 1'b1);
    checkOutput("t5_tx_cnt_before", bus.tx_cnt, 16'd4);
    reset       = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h65;
    cycle();
    sb.delete();
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    checkBit("t5_en_zero", bus.input_en, 1'b0);
    checkBit("t5_last_zero", bus.input_last, 1'b0);
    checkOutput("t5_data_zero", 16'(bus.input_data), 16'h0);
    checkOutput("t5_tx_cnt_zero", bus.tx_cnt, 16'd0);
    checkBit("t5_busy_zero", bus.busy, 1'b0);
    repeat (5) cycle();
    applyStimulus(8'h70, 1'b0, 1'b1);
    applyStimulus(8'h71, 1'b1, 1'b1);
    drain(10, 1'b0);
    checkOutput("t5_tx_cnt_new", bus.tx_cnt, 16'd2);

    $display("[TB] long frame with random back-pressure");
    base = issued;
    for (int i = 0; i < 40; i++) begin
      bus.max_in_en_val = ($urandom_range(0, 3) == 0);
      applyStimulus(8'($urandom_range(0, 255)), i == 39, 1'b1);
      bus.max_in_en_val = ($urandom_range(0, 3) == 0);
      cycle();
    end
    drain(60, 1'b0);
    checkOutput("t6_issued", 16'(issued - base), 16'd40);
    checkOutput("t6_tx_cnt", bus.tx_cnt, 16'd40);
    checkBit("t6_ovf_clear", bus.ovf_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ccm_ctr_feeder.md
CCM_CTR_FEEDER -- requirements
Module: ccm_ctr_feeder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data byte width.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the staging FIFO entries; it SHALL be a power of two and at least 4.
REQ-003 Port clk, input, 1: the single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port wr_data, input, WIDTH: upstream payload byte.
REQ-006 Port wr_en, input, 1: upstream write strobe.
REQ-007 Port wr_last, input, 1: marks the final byte of a frame; qualified by wr_en.
REQ-008 Port wr_full, output, 1: FIFO holds FIFO_DEPTH entries (combinational from the count).
REQ-009 Port input_data, output, WIDTH: byte to the ccm_ctr core.
REQ-010 Port input_en, output, 1: input_data valid toward the core.
REQ-011 Port input_last, output, 1: final byte of a frame toward the core.
REQ-012 Port max_in_en_val, input, 1: core back-pressure; high means the core accepts no byte this cycle.
REQ-013 Port tx_cnt, output, 16: bytes issued in the current frame.
REQ-014 Port busy, output, 1: a frame is in progress (state not IDLE).
REQ-015 Port ovf_err, output, 1: sticky overflow flag.

Function
REQ-016 The FIFO SHALL store {wr_last, wr_data} per entry and accept a write when wr_en=1 and wr_full=0.
REQ-017 A write with wr_full=1 SHALL be dropped, even if a read occurs that cycle, and SHALL set ovf_err.
REQ-018 Read-pointer and write-pointer arithmetic SHALL wrap modulo FIFO_DEPTH; the count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-019 A simultaneous read and write with the FIFO neither empty nor full SHALL leave the count unchanged.
REQ-020 input_data, input_en and input_last SHALL be registered outputs.
REQ-021 In a cycle where FIFO is non-empty, max_in_en_val=0 and state is IDLE or SEND, the block SHALL pop one entry, and the next cycle SHALL have input_en=1, input_data=entry data and input_last=entry last.
REQ-022 In any other cycle the block SHALL NOT pop, and the next cycle SHALL have input_en=0 and input_last=0; input_data SHALL hold its previous value.
REQ-023 Latency: a byte written into an empty FIFO at edge N with max_in_en_val=0 SHALL appear with input_en=1 after edge N+1.
REQ-024 The FSM SHALL have the states IDLE, SEND and GAP.
REQ-025 In IDLE, a pop SHALL move the FSM to SEND and load tx_cnt=1; if the popped entry has last=1, the FSM SHALL go directly to GAP.
REQ-026 In SEND, each pop SHALL increment tx_cnt, saturating at 16'hFFFF; a pop with last=1 SHALL move the FSM to GAP.
REQ-027 An empty FIFO in SEND SHALL create bubbles (input_en=0) with no error and no state change.
REQ-028 GAP SHALL last exactly one cycle with no pop, then return to IDLE; this guarantees at least one idle cycle between frames.
REQ-029 tx_cnt SHALL hold its final value through GAP and IDLE until the next frame's first pop.
REQ-030 A single-byte frame SHALL produce one cycle with input_en=1 and input_last=1, and tx_cnt=1.
REQ-031 max_in_en_val SHALL only gate pops; it SHALL never cancel a byte already registered on the outputs.

Reset
REQ-032 With reset=1 sampled at an edge, the block SHALL set: FIFO empty, pointers 0, FSM IDLE, input_en=0, input_last=0, input_data=0, tx_cnt=0, ovf_err=0. busy=0 and wr_full=0 SHALL follow from that state.
REQ-033 Reset mid-frame SHALL discard all FIFO contents, and the core interface SHALL be quiet from the next cycle onward.
REQ-034 Writes presented while reset=1 SHALL be ignored.

Verification
REQ-035 Write 5 bytes 8'h01..8'h05 (last on 8'h05) with max_in_en_val=0: input_en SHALL be high for 5 consecutive cycles with data 01..05, input_last SHALL be high only with 05, tx_cnt=5, and busy SHALL drop two cycles after the last byte is issued.
REQ-036 Hold max_in_en_val=1 and write 16 bytes: wr_full=1 and input_en=0; a 17th write SHALL set ovf_err=1; releasing max_in_en_val SHALL issue 16 bytes in order, with none lost.
REQ-037 Toggle max_in_en_val every cycle during a 10-byte frame: input_en SHALL never follow a cycle where max_in_en_val=1; the byte order and tx_cnt=10 SHALL be preserved.
REQ-038 Write two back-to-back frames (3 bytes and 1 byte) in consecutive cycles: at least one cycle with input_en=0 SHALL separate the frames, and the second frame SHALL show input_last=1 together with input_en=1.
REQ-039 Assert reset after 4 of 8 bytes of a frame are issued: the outputs SHALL be 0 the next cycle and no remaining byte SHALL be issued; a subsequent 2-byte frame SHALL report tx_cnt=2.
REQ-040 Write 40 bytes at one byte every 2 cycles with random back-pressure: the pointers SHALL wrap, the output SHALL equal the input sequence, and ovf_err SHALL stay 0.
